// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port data memory between a CPU and a DMA/debug
// requester, with a fixed-latency access sequence and a DMA anti-starvation limit.
module mem_port_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_done,
   output logic        cpu_stall,
   output logic [31:0] cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_done,
   output logic [31:0] dma_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  state_dbg
);

   // Handshake: a requester holds req with we/addr/wdata stable until it sees
   // its gnt (one cycle, in IDLE); the request is captured on that edge and
   // finishes with exactly one done pulse, whatever req does afterwards.

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   cpu_rdata_q, cpu_rdata_d;
   logic [31:0]   dma_rdata_q, dma_rdata_d;
   logic [3:0]    lat_q, lat_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          contended;
   logic          dma_wins;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      lat_d       = lat_q;
      starve_d    = starve_q;
      cpu_gnt     = 1'b0;
      dma_gnt     = 1'b0;
      cpu_done    = 1'b0;
      dma_done    = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      contended   = cpu_req & dma_req;
      // owner encoding: 0 = CPU, 1 = DMA
      dma_wins    = dma_req & (~cpu_req | (starve_q == SW'(STARVE_MAX)));

      case (state_q)
         IDLE: begin
            if (cpu_req || dma_req) begin
               owner_d = dma_wins;
               lat_d   = 4'(MEM_LAT - 1);
               state_d = ACCESS;
               if (dma_wins) begin
                  we_d     = dma_we;
                  addr_d   = dma_addr;
                  wdata_d  = dma_wdata;
                  dma_gnt  = rst_n;
                  starve_d = '0;
               end else begin
                  we_d    = cpu_we;
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
                  cpu_gnt = rst_n;
                  if (contended) starve_d = starve_q + SW'(1);
               end
            end
         end
         ACCESS: begin
            mem_read  = ~we_q;
            mem_write = we_q;
            if (lat_q == 4'd0) begin
               if (!we_q) begin
                  if (owner_q) dma_rdata_d = mem_rdata;
                  else         cpu_rdata_d = mem_rdata;
               end
               state_d = DONE;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         DONE: begin
            cpu_done = ~owner_q;
            dma_done = owner_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         lat_q       <= '0;
         starve_q    <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         lat_q       <= lat_d;
         starve_q    <= starve_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign cpu_stall = cpu_req & ~cpu_done;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scenario tasks plus a scoreboard
// of expected accesses consumed by a memory-side monitor.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_done, cpu_stall, dma_gnt, dma_done;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic [1:0]  state_dbg;

  logic        c1_req;
  logic [31:0] c1_addr;
  logic        c1_gnt, c1_done, c1_stall, d1_gnt, d1_done;
  logic [31:0] c1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
  logic        m1_read, m1_write;
  logic [1:0]  st1_dbg;

  exp_t        exp_q[$];
  logic [31:0] m_cpu_rdata, m_dma_rdata;
  int          tests_run = 0;
  int          fail_cnt  = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata = mem_read ? mem_model(mem_addr) : 32'h0BAD0BAD;
  assign m1_rdata  = m1_read  ? mem_model(m1_addr)  : 32'h0BAD0BAD;

  mem_port_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr), .cpu_wdata(32'h0),
    .cpu_gnt(c1_gnt), .cpu_done(c1_done), .cpu_stall(c1_stall), .cpu_rdata(c1_rdata),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_gnt(d1_gnt), .dma_done(d1_done), .dma_rdata(d1_rdata),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_read(m1_read), .mem_write(m1_write),
    .mem_rdata(m1_rdata), .state_dbg(st1_dbg)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests_run);
    $fatal(1);
  end

  // monitor: memory strobes and done pulses against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      tests_run++;
      if (mem_read && mem_write) begin
        fail_cnt++;
        $display("FAIL strobe_excl: read=%b write=%b, required not both", mem_read, mem_write);
      end
      if (mem_read || mem_write) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL strobe_unexpected: addr=%h with empty scoreboard", mem_addr);
        end else begin
          e = exp_q[0];
          if (mem_addr !== e.addr || mem_write !== e.we || (e.we && mem_wdata !== e.wdata)) begin
            fail_cnt++;
            $display("FAIL strobe_data: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                     mem_addr, mem_write, mem_wdata, e.addr, e.we, e.wdata);
          end
        end
      end
      if (cpu_done || dma_done) begin
        tests_run++;
        if (exp_q.size() == 0 || (cpu_done && dma_done)) begin
          fail_cnt++;
          $display("FAIL done_unexpected: cpu_done=%b dma_done=%b queue=%0d", cpu_done, dma_done, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          if (dma_done !== e.owner) begin
            fail_cnt++;
            $display("FAIL done_owner: dma_done=%b, required %b", dma_done, e.owner);
          end
          if (!e.we) begin
            if (e.owner) m_dma_rdata = e.rdata;
            else         m_cpu_rdata = e.rdata;
          end
          tests_run++;
          if (cpu_rdata !== m_cpu_rdata || dma_rdata !== m_dma_rdata) begin
            fail_cnt++;
            $display("FAIL rdata: cpu=%h dma=%h, required cpu=%h dma=%h",
                     cpu_rdata, dma_rdata, m_cpu_rdata, m_dma_rdata);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic push_exp(input logic owner, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.owner = owner; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = mem_model(addr);
    exp_q.push_back(e);
  endtask

  task automatic drive_req(input logic owner, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    if (owner) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  task automatic wait_queue_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL %s_drain: %0d accesses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_access(input logic owner, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int  n;
    logic seen;
    push_exp(owner, we, addr, wdata);
    @(posedge clk); #1;
    drive_req(owner, we, addr, wdata);
    seen = 1'b0; n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = owner ? dma_gnt : cpu_gnt;
      n++;
    end
    tests_run++;
    if (!seen) begin
      fail_cnt++;
      $display("FAIL access_gnt: owner=%b no grant within 50 cycles", owner);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; dma_req = 1'b0;
    wait_queue_empty("access");
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    c1_req = 0; c1_addr = 0;
    m_cpu_rdata = 0; m_dma_rdata = 0;
    repeat (3) @(posedge clk);
    cpu_req = 1'b1; dma_req = 1'b1;
    #1;
    tests_run++;
    if ({cpu_gnt, dma_gnt, cpu_done, dma_done, mem_read, mem_write} !== 6'b0) begin
      fail_cnt++;
      $display("FAIL reset_strobes: gnt=%b%b done=%b%b rd=%b wr=%b, required all 0",
               cpu_gnt, dma_gnt, cpu_done, dma_done, mem_read, mem_write);
    end
    tests_run++;
    if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 128'b0) begin
      fail_cnt++;
      $display("FAIL reset_data: addr=%h wdata=%h crd=%h drd=%h, required 0", mem_addr, mem_wdata, cpu_rdata, dma_rdata);
    end
    tests_run++;
    if (state_dbg !== 2'd0 || st1_dbg !== 2'd0) begin
      fail_cnt++;
      $display("FAIL reset_state: state=%0d/%0d, required 0", state_dbg, st1_dbg);
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (state_dbg !== 2'd0 || cpu_gnt !== 1'b0) begin
      fail_cnt++;
      $display("FAIL idle_no_req: state=%0d gnt=%b, required 0/0", state_dbg, cpu_gnt);
    end
  endtask

  task automatic test_cpu_read();
    push_exp(1'b0, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (cpu_gnt !== (c == 0) || mem_read !== (c == 1 || c == 2) || cpu_done !== (c == 3) || mem_write !== 1'b0) begin
        fail_cnt++;
        $display("FAIL cpu_read_c%0d: gnt=%b rd=%b wr=%b done=%b, required %b %b 0 %b",
                 c, cpu_gnt, mem_read, mem_write, cpu_done, c == 0, c == 1 || c == 2, c == 3);
      end
      if (c == 0) begin
        @(posedge clk); #1;
        cpu_req = 1'b0;
      end
    end
    tests_run++;
    if (cpu_rdata !== 32'hDEADBEEF || dma_rdata !== 32'h0) begin
      fail_cnt++;
      $display("FAIL cpu_read_rdata: cpu=%h dma=%h, required DEADBEEF 0", cpu_rdata, dma_rdata);
    end
    wait_queue_empty("cpu_read");
  endtask

  task automatic test_dma_write();
    int dones = 0;
    push_exp(1'b1, 1'b1, 32'h40, 32'h12345678);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, 32'h40, 32'h12345678);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests_run++;
      if (dma_gnt !== (c == 0) || mem_write !== (c == 1 || c == 2) || mem_read !== 1'b0) begin
        fail_cnt++;
        $display("FAIL dma_write_c%0d: gnt=%b wr=%b rd=%b, required %b %b 0",
                 c, dma_gnt, mem_write, mem_read, c == 0, c == 1 || c == 2);
      end
      if (dma_done) dones++;
      if (c == 0) begin
        @(posedge clk); #1;
        dma_req = 1'b0;
        dma_addr = 32'h77; dma_wdata = 32'h0;
      end
    end
    tests_run++;
    if (dones != 1 || cpu_rdata !== 32'hDEADBEEF || dma_rdata !== 32'h0 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678) begin
      fail_cnt++;
      $display("FAIL dma_write_after: dones=%0d crd=%h drd=%h addr=%h wdata=%h, required 1 DEADBEEF 0 40 12345678",
               dones, cpu_rdata, dma_rdata, mem_addr, mem_wdata);
    end
    wait_queue_empty("dma_write");
  endtask

  task automatic test_starvation();
    logic log_q[$];
    int   n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 3) push_exp(1'b1, 1'b0, 32'h200, 32'h0);
      else            push_exp(1'b0, 1'b0, 32'h100, 32'h0);
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h100, 32'h0);
    drive_req(1'b1, 1'b0, 32'h200, 32'h0);
    while (log_q.size() < 8 && n < 200) begin
      @(negedge clk);
      n++;
      if (cpu_gnt) log_q.push_back(1'b0);
      if (dma_gnt) log_q.push_back(1'b1);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; dma_req = 1'b0;
    tests_run++;
    if (log_q.size() != 8) begin
      fail_cnt++;
      $display("FAIL starve_count: %0d grants, required 8", log_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (log_q[i] !== (i % 4 == 3)) begin
          fail_cnt++;
          $display("FAIL starve_order%0d: dma=%b, required %b", i, log_q[i], i % 4 == 3);
        end
      end
    end
    wait_queue_empty("starve");
  endtask

  task automatic test_drop_and_change();
    int   n = 0;
    logic seen = 1'b0;
    push_exp(1'b0, 1'b0, 32'h20, 32'h0);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    tests_run++;
    if (cpu_gnt !== 1'b1) begin
      fail_cnt++;
      $display("FAIL drop_gnt: gnt=%b, required 1", cpu_gnt);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_addr = 32'h99; cpu_we = 1'b1; cpu_wdata = 32'hCAFEF00D;
    while (!seen && n < 10) begin
      @(negedge clk);
      seen = cpu_done;
      n++;
    end
    tests_run++;
    if (!seen || cpu_rdata !== mem_model(32'h20)) begin
      fail_cnt++;
      $display("FAIL drop_done: done_seen=%b rdata=%h, required 1 %h", seen, cpu_rdata, mem_model(32'h20));
    end
    cpu_we = 1'b0;
    wait_queue_empty("drop");
  endtask

  task automatic test_reset_mid_access();
    int dones = 0;
    push_exp(1'b0, 1'b0, 32'h30, 32'h0);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h30, 32'h0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_cpu_rdata = 0; m_dma_rdata = 0;
    #1;
    tests_run++;
    if (mem_read !== 1'b0 || cpu_rdata !== 32'h0 || dma_rdata !== 32'h0 || state_dbg !== 2'd0) begin
      fail_cnt++;
      $display("FAIL midreset: rd=%b crd=%h drd=%h state=%0d, required 0 0 0 0", mem_read, cpu_rdata, dma_rdata, state_dbg);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (cpu_done || dma_done) dones++;
    end
    tests_run++;
    if (dones != 0 || cpu_rdata !== 32'h0) begin
      fail_cnt++;
      $display("FAIL midreset_after: dones=%0d rdata=%h, required 0 0", dones, cpu_rdata);
    end
    do_access(1'b0, 1'b0, 32'h34, 32'h0);
  endtask

  task automatic test_random();
    logic        owner, we;
    logic [31:0] addr, wdata;
    for (int i = 0; i < 8; i++) begin
      owner = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = {$urandom_range(0, 16'hFFFF), 2'b00};
      wdata = $urandom;
      do_access(owner, we, addr, wdata);
    end
  endtask

  task automatic test_back_to_back_lat1();
    @(posedge clk); #1;
    c1_req = 1'b1; c1_addr = 32'h44;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tests_run++;
      if (c1_gnt !== (c % 3 == 0) || c1_done !== (c % 3 == 2) || c1_stall !== (c % 3 != 2) || m1_read !== (c % 3 == 1)) begin
        fail_cnt++;
        $display("FAIL b2b_c%0d: gnt=%b done=%b stall=%b rd=%b, required %b %b %b %b",
                 c, c1_gnt, c1_done, c1_stall, m1_read, c % 3 == 0, c % 3 == 2, c % 3 != 2, c % 3 == 1);
      end
    end
    @(posedge clk); #1;
    c1_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (c1_rdata !== mem_model(32'h44) || c1_gnt !== 1'b0 || c1_stall !== 1'b0) begin
      fail_cnt++;
      $display("FAIL b2b_end: rdata=%h gnt=%b stall=%b, required %h 0 0", c1_rdata, c1_gnt, c1_stall, mem_model(32'h44));
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_starvation();
    test_drop_and_change();
    test_reset_mid_access();
    test_random();
    test_back_to_back_lat1();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning the number of cycles each memory access is held; legal range is 1..15.
REQ-002 SHALL have parameter STARVE_MAX, default 3, meaning the maximum number of consecutive contended arbitrations the CPU may win before DMA is forced to win.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset; one clock, asynchronous assertion, active-low.
REQ-005 cpu_req / cpu_we  in  1 / 1  CPU access request / write-not-read.
REQ-006 cpu_addr / cpu_wdata  in  32 / 32  CPU byte address / write data.
REQ-007 cpu_gnt / cpu_done / cpu_stall  out  1 / 1 / 1  CPU request accepted / access complete / CPU must hold its state registers.
REQ-008 cpu_rdata  out  32  last CPU read data.
REQ-009 dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata SHALL have the same widths and meanings as the cpu_* ports, applied to the DMA/debug requester.
REQ-010 mem_addr / mem_wdata  out  32 / 32  single-port data memory address / write data.
REQ-011 mem_read / mem_write  out  1 / 1  memory read / write strobe.
REQ-012 mem_rdata  in  32  memory read data, valid while mem_read is asserted.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-014 IDLE with no request SHALL remain in IDLE.
REQ-015 IDLE with any request SHALL arbitrate, latch owner, we, addr and wdata, pulse the owner's gnt for that cycle, and go to ACCESS with the latency counter loaded with MEM_LAT-1.
REQ-016 Arbitration SHALL be:
- only one requester active: that requester wins;
- both active: CPU wins unless the contended-win counter equals STARVE_MAX, in which case DMA wins.
REQ-017 The contended-win counter SHALL increment on each contended CPU win and clear on every DMA grant.
REQ-018 ACCESS SHALL drive mem_addr/mem_wdata from the latched values, assert mem_write if we else mem_read, and decrement the counter each cycle.
REQ-019 ACCESS with counter 0 SHALL, for a read, capture mem_rdata into the owner's rdata register, then go to DONE; total strobe time is exactly MEM_LAT cycles.
REQ-020 DONE SHALL pulse the owner's done for one cycle, deassert mem_read/mem_write and go to IDLE, giving an access period of MEM_LAT+2 cycles.
REQ-021 mem_read and mem_write SHALL never be asserted together and SHALL be 0 outside ACCESS.
REQ-022 mem_addr/mem_wdata SHALL hold their last latched values outside ACCESS.
REQ-023 cpu_stall SHALL equal cpu_req AND NOT cpu_done, combinationally.
REQ-024 Deasserting a request after its gnt SHALL NOT abort the access; done still pulses.
REQ-025 Changes to addr, wdata or we after gnt SHALL be ignored until the next grant.
REQ-026 An rdata output SHALL change only on completion of that requester's read; writes and the other requester's accesses SHALL leave it unchanged.
REQ-027 A request asserted during ACCESS or DONE SHALL wait and be arbitrated in the next IDLE cycle.

Reset
REQ-028 rst_n low SHALL immediately force IDLE and set the latency and contended-win counters to 0.
REQ-029 rst_n low SHALL immediately set all gnt/done/mem_read/mem_write outputs to 0 and mem_addr, mem_wdata and both rdata outputs to 0.
REQ-030 Reset during ACCESS SHALL abort the access with no done pulse and no rdata update.

Verification
REQ-031 CPU read, addr 0x10, mem_rdata 0xDEADBEEF, MEM_LAT=2 -> cpu_gnt at cycle 0, mem_read in cycles 1-2, cpu_done at cycle 3, cpu_rdata=0xDEADBEEF, dma_rdata unchanged.
REQ-032 DMA write, addr 0x40, data 0x12345678 -> mem_write high for 2 cycles with those values, dma_done once, both rdata outputs unchanged.
REQ-033 Both requesters held high continuously, STARVE_MAX=3 -> grant order CPU, CPU, CPU, DMA, CPU, CPU, CPU, DMA.
REQ-034 cpu_req dropped the cycle after cpu_gnt, cpu_addr changed to 0x99 -> access completes at the originally latched address and cpu_done pulses.
REQ-035 rst_n pulsed low mid-ACCESS -> mem_read=0 immediately, no done pulse, rdata=0, next request granted normally.
REQ-036 MEM_LAT=1 back-to-back CPU reads -> cpu_gnt every 3 cycles, cpu_stall low only in the cpu_done cycles.
